four_bit_adder_checker: RTL

FOUR_BIT_ADDER_CHECKER -- requirements
Module: four_bit_adder_checker

---
 rtl/four_bit_adder_checker_pkg.sv | 17 +
 rtl/checker_fifo.sv | 53 +++++
 rtl/four_bit_adder_checker.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/four_bit_adder_checker_pkg.sv
// rtl/four_bit_adder_checker_pkg.sv - shared state encoding and tally constants for the adder checker
package four_bit_adder_checker_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_HALTED  = 2'd2
    } chk_state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/checker_fifo.sv
// rtl/checker_fifo.sv - circular FIFO of pending vectors with occupancy counter
module checker_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign rdata = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // DEPTH is a power of two, so pointer wrap is the natural overflow of AW bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/four_bit_adder_checker.sv
// rtl/four_bit_adder_checker.sv - scoreboard comparing adder results against queued expected sums
module four_bit_adder_checker
    import four_bit_adder_checker_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int DEPTH        = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             clear,
    output logic [15:0]      pass_count,
    output logic [15:0]      fail_count,
    output logic             mismatch,
    output logic             error,
    output logic             orphan,
    output logic             overflow,
    output logic             halted,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic             ff_cin,
    output logic [WIDTH-1:0] ff_sum,
    output logic             ff_cout
);

    localparam int EW = 3*WIDTH + 2;
    localparam int AW = $clog2(DEPTH);

    chk_state_t state, state_nxt;

    logic [WIDTH:0]  in_total;
    logic [EW-1:0]   wdata, rdata, cmp_entry;
    logic [AW:0]     q_count, occ_nxt;
    logic            q_empty, q_full;
    logic            active, bypass, push, pop;
    logic            orphan_ev, ovf_ev, cmp_ev, fail_ev, pass_ev;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic            cmp_cin;
    logic [WIDTH:0]  cmp_exp;

    // Entry layout: {a, b, cin, exp_cout, exp_sum}
    assign in_total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign wdata    = {a, b, cin, in_total};

    assign active    = (state != ST_HALTED) && !clear;
    assign bypass    = active && in_valid && res_valid && q_empty;
    assign pop       = active && res_valid && !q_empty;
    assign orphan_ev = active && res_valid && !in_valid && q_empty;
    assign push      = active && in_valid && !bypass && (!q_full || pop);
    assign ovf_ev    = active && in_valid && q_full && !pop;

    assign cmp_entry = bypass ? wdata : rdata;
    assign cmp_a     = cmp_entry[EW-1 -: WIDTH];
    assign cmp_b     = cmp_entry[EW-1-WIDTH -: WIDTH];
    assign cmp_cin   = cmp_entry[WIDTH+1];
    assign cmp_exp   = cmp_entry[WIDTH:0];

    assign cmp_ev  = bypass || pop;
    assign fail_ev = cmp_ev && ({cout, sum} != cmp_exp);
    assign pass_ev = cmp_ev && !fail_ev;

    assign occ_nxt = q_count + (AW+1)'(push) - (AW+1)'(pop);
    assign halted  = (state == ST_HALTED);

    checker_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_EMPTY;
        end else if (state != ST_HALTED) begin
            if (fail_ev && (STOP_ON_FAIL != 0)) state_nxt = ST_HALTED;
            else if (occ_nxt == '0)             state_nxt = ST_EMPTY;
            else                                state_nxt = ST_PENDING;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_count <= '0;
            fail_count <= '0;
            mismatch   <= 1'b0;
            error      <= 1'b0;
            orphan     <= 1'b0;
            overflow   <= 1'b0;
            ff_a       <= '0;
            ff_b       <= '0;
            ff_cin     <= 1'b0;
            ff_sum     <= '0;
            ff_cout    <= 1'b0;
        end else if (clear) begin
            pass_count <= '0;
            fail_count <= '0;
            mismatch   <= 1'b0;
            error      <= 1'b0;
            orphan     <= 1'b0;
            overflow   <= 1'b0;
            ff_a       <= '0;
            ff_b       <= '0;
            ff_cin     <= 1'b0;
            ff_sum     <= '0;
            ff_cout    <= 1'b0;
        end else begin
            mismatch <= fail_ev;
            if (pass_ev) pass_count <= sat_inc(pass_count);
            if (fail_ev) fail_count <= sat_inc(fail_count);
            if (fail_ev || orphan_ev || ovf_ev) error <= 1'b1;
            if (orphan_ev) orphan   <= 1'b1;
            if (ovf_ev)    overflow <= 1'b1;
            // A saturated fail tally never returns to zero, so zero means no prior failure
            if (fail_ev && (fail_count == '0)) begin
                ff_a    <= cmp_a;
                ff_b    <= cmp_b;
                ff_cin  <= cmp_cin;
                ff_sum  <= sum;
                ff_cout <= cout;
            end
        end
    end

endmodule
